// File: rtl/irq_arbiter_if.sv
// Register bus, interrupt sources and core-side handshake of the IRQ arbiter.
// The arbiter takes the slave side and the driver takes the master side.
interface irq_arbiter_if;
    logic [3:0]  irq_src_i;
    logic        we_i;
    logic [7:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        clint_busy_i;
    logic [7:0]  int_flag_o;
    logic        irq_active_o;

    modport master (
        output irq_src_i, we_i, addr_i, wdata_i, clint_busy_i,
        input  rdata_o, int_flag_o, irq_active_o
    );

    modport slave (
        input  irq_src_i, we_i, addr_i, wdata_i, clint_busy_i,
        output rdata_o, int_flag_o, irq_active_o
    );
endinterface

// File: rtl/irq_arbiter.sv
// 4-source priority interrupt arbiter with claim/complete handshake.
// Define IRQ_ARBITER_SYNC_EN to add a 2-flop synchroniser on each source.
module irq_arbiter (
    input  logic          clk,
    input  logic          rst_n,
    irq_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  id_q, id_d;
    logic [3:0]  src_s, src_prev, rise;
    logic [3:0]  pend_q, pending, clr;
    logic [3:0]  enable_q, mode_q, elig;
    logic [7:0]  prio_q;
    logic [1:0]  thr_q, best;
    logic        win_valid, accept, claim_wr;
    logic [1:0]  win_id;
    logic [2:0]  claim_id;

`ifdef IRQ_ARBITER_SYNC_EN
    logic [3:0] sync1, sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.irq_src_i;
            sync2 <= sync1;
        end
    end

    assign src_s = sync2;
`else
    assign src_s = bus.irq_src_i;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) src_prev <= '0;
        else        src_prev <= src_s;
    end

    assign rise     = src_s & ~src_prev;
    assign pending  = (mode_q & pend_q) | (~mode_q & src_s);
    assign claim_id = {1'b0, id_q} + 3'd1;
    assign claim_wr = bus.we_i && (bus.addr_i == 8'h10) &&
                      (bus.wdata_i[2:0] == claim_id);

    always_comb begin
        elig      = '0;
        win_valid = 1'b0;
        win_id    = '0;
        best      = '0;
        // Strict compare keeps the lowest index on a priority tie.
        for (int i = 0; i < 4; i++) begin
            elig[i] = pending[i] & enable_q[i] &
                      (prio_q[2*i +: 2] > thr_q);
            if (elig[i] && (prio_q[2*i +: 2] > best)) begin
                win_valid = 1'b1;
                win_id    = 2'(i);
                best      = prio_q[2*i +: 2];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = ASSERT;
                    id_d    = win_id;
                end
            end
            ASSERT: begin
                if (bus.clint_busy_i) begin
                    accept  = 1'b1;
                    state_d = SERVICE;
                end else if (!elig[id_q]) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (claim_wr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign clr = accept ? (4'b0001 << id_q) : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            id_q     <= '0;
            pend_q   <= '0;
            enable_q <= '0;
            prio_q   <= '0;
            thr_q    <= '0;
            mode_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            // A new edge in the acceptance cycle keeps the bit set.
            pend_q  <= (pend_q & ~clr) | rise;
            if (bus.we_i) begin
                case (bus.addr_i)
                    8'h04:   enable_q <= bus.wdata_i[3:0];
                    8'h08:   prio_q   <= bus.wdata_i[7:0];
                    8'h0C:   thr_q    <= bus.wdata_i[1:0];
                    8'h14:   mode_q   <= bus.wdata_i[3:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus.rdata_o = '0;
        case (bus.addr_i)
            8'h00:   bus.rdata_o[3:0] = pending;
            8'h04:   bus.rdata_o[3:0] = enable_q;
            8'h08:   bus.rdata_o[7:0] = prio_q;
            8'h0C:   bus.rdata_o[1:0] = thr_q;
            8'h10: begin
                if (state_q == SERVICE) bus.rdata_o[2:0] = claim_id;
            end
            8'h14:   bus.rdata_o[3:0] = mode_q;
            default: ;
        endcase
    end

    assign bus.int_flag_o   = (state_q == ASSERT) ? (8'h01 << id_q) : 8'h00;
    assign bus.irq_active_o = (state_q != IDLE);
endmodule

// File: tb/tb_irq_arbiter.sv
// Directed self-checking bench for irq_arbiter: register table plus
// hand-written arbitration, withdrawal, claim and reset sequences.
module tb_irq_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    irq_arbiter_if bus ();

    irq_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.we_i    = 1'b1;
        bus.addr_i  = a;
        bus.wdata_i = d;
        @(negedge clk);
        bus.we_i    = 1'b0;
        bus.addr_i  = 8'h00;
        bus.wdata_i = '0;
    endtask

    task automatic rd(input string nm, input logic [7:0] a,
                      input logic [31:0] exp);
        bus.addr_i = a;
        #1;
        chk(nm, bus.rdata_o, exp);
        bus.addr_i = 8'h00;
    endtask

    task automatic wait_rd(input string nm, input logic [7:0] a,
                           input logic [31:0] exp);
        logic ok;
        ok = 1'b0;
        bus.addr_i = a;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (bus.rdata_o === exp) ok = 1'b1;
        end
        chk(nm, bus.rdata_o, exp);
        bus.addr_i = 8'h00;
    endtask

    task automatic wait_flag(input string nm, input logic [7:0] exp);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (bus.int_flag_o === exp) ok = 1'b1;
        end
        chk(nm, {24'h0, bus.int_flag_o}, {24'h0, exp});
    endtask

    task automatic pulse(input logic [3:0] m);
        @(negedge clk);
        bus.irq_src_i = m;
        @(negedge clk);
        bus.irq_src_i = 4'h0;
    endtask

    task automatic accept(input string nm, input logic [31:0] claim);
        @(negedge clk);
        bus.clint_busy_i = 1'b1;
        @(negedge clk);
        bus.clint_busy_i = 1'b0;
        chk({nm, "_flag"}, {24'h0, bus.int_flag_o}, 32'h0);
        chk({nm, "_active"}, {31'h0, bus.irq_active_o}, 32'h1);
        rd({nm, "_claim"}, 8'h10, claim);
    endtask

    task automatic reset_rd_all(input string nm);
        logic [7:0] offs [6];
        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};
        for (int i = 0; i < 6; i++) rd(nm, offs[i], 32'h0);
        chk({nm, "_flag"}, {24'h0, bus.int_flag_o}, 32'h0);
        chk({nm, "_active"}, {31'h0, bus.irq_active_o}, 32'h0);
    endtask

    initial begin
        logic bad;
        checks = 0;
        errors = 0;
        vecs[0] = '{8'h04, 32'hFFFF_FFFF, 32'h0000_000F};
        vecs[1] = '{8'h08, 32'hFFFF_FFFF, 32'h0000_00FF};
        vecs[2] = '{8'h0C, 32'hFFFF_FFFF, 32'h0000_0003};
        vecs[3] = '{8'h14, 32'h0000_00AB, 32'h0000_000B};
        vecs[4] = '{8'h00, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[5] = '{8'h10, 32'h0000_0005, 32'h0000_0000};
        vecs[6] = '{8'h18, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[7] = '{8'hFC, 32'h1234_5678, 32'h0000_0000};

        rst_n            = 1'b0;
        bus.irq_src_i    = 4'h0;
        bus.we_i         = 1'b0;
        bus.addr_i       = 8'h00;
        bus.wdata_i      = '0;
        bus.clint_busy_i = 1'b0;
        repeat (3) @(negedge clk);
        reset_rd_all("reset");
        rst_n = 1'b1;

        // Register map: write then read back masked value
        for (int i = 0; i < 8; i++) begin
            wr(vecs[i].addr, vecs[i].wdata);
            rd($sformatf("reg_%02h", vecs[i].addr), vecs[i].addr,
               vecs[i].exp);
        end
        chk("tbl_no_irq", {24'h0, bus.int_flag_o}, 32'h0);
        wr(8'h04, 0); wr(8'h08, 0); wr(8'h0C, 0); wr(8'h14, 0);

        // Single edge source end to end
        wr(8'h04, 1); wr(8'h08, 1); wr(8'h0C, 0); wr(8'h14, 1);
        pulse(4'h1);
        wait_flag("t1_flag", 8'h01);
        chk("t1_active", {31'h0, bus.irq_active_o}, 32'h1);
        rd("t1_pend", 8'h00, 32'h1);
        rd("t1_claim_assert", 8'h10, 32'h0);
        accept("t1_acc", 32'h1);
        rd("t1_pend_clr", 8'h00, 32'h0);
        wr(8'h10, 1);
        chk("t1_idle", {31'h0, bus.irq_active_o}, 32'h0);
        rd("t1_claim_idle", 8'h10, 32'h0);

        // Priority with tie to lowest index
        wr(8'h04, 32'hF); wr(8'h08, 32'h7C); wr(8'h14, 32'hF);
        pulse(4'hE);
        wait_flag("t2_win1", 8'h02);
        accept("t2_acc1", 32'h2);
        wr(8'h10, 2);
        chk("t2_gap", {24'h0, bus.int_flag_o}, 32'h0);
        wait_flag("t2_win2", 8'h04);
        accept("t2_acc2", 32'h3);
        wr(8'h10, 3);
        wait_flag("t2_win3", 8'h08);
        accept("t2_acc3", 32'h4);
        wr(8'h10, 4);
        chk("t2_done", {31'h0, bus.irq_active_o}, 32'h0);

        // Wrong claim ignored, edge during service re-asserts later
        wr(8'h04, 1); wr(8'h08, 1); wr(8'h14, 1);
        pulse(4'h1);
        wait_flag("t4_flag", 8'h01);
        accept("t4_acc", 32'h1);
        wr(8'h10, 3);
        rd("t4_bad_claim", 8'h10, 32'h1);
        chk("t4_still_act", {31'h0, bus.irq_active_o}, 32'h1);
        pulse(4'h1);
        wait_rd("t4_pend_svc", 8'h00, 32'h1);
        chk("t4_svc_flag", {24'h0, bus.int_flag_o}, 32'h0);
        wr(8'h10, 1);
        chk("t4_gap", {24'h0, bus.int_flag_o}, 32'h0);
        wait_flag("t4_reassert", 8'h01);
        accept("t4_acc2", 32'h1);
        wr(8'h10, 1);

        // Level mode threshold, then withdrawal
        wr(8'h14, 0); wr(8'h08, 2); wr(8'h0C, 2); wr(8'h04, 1);
        @(negedge clk);
        bus.irq_src_i = 4'h1;
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.int_flag_o !== 8'h00) bad = 1'b1;
        end
        chk("t3_thr_block", {31'h0, bad}, 32'h0);
        wr(8'h0C, 1);
        wait_flag("t3_thr_pass", 8'h01);
        wr(8'h04, 0);
        wait_flag("t3_withdraw", 8'h00);
        chk("t3_wd_idle", {31'h0, bus.irq_active_o}, 32'h0);
        rd("t3_wd_claim", 8'h10, 32'h0);
        wr(8'h04, 1);
        wait_flag("t3_rearb", 8'h01);
        accept("t3_acc", 32'h1);

        // Reset during service, edge seen at release
        @(negedge clk);
        rst_n         = 1'b0;
        bus.irq_src_i = 4'h0;
        reset_rd_all("mid_rst");
        @(negedge clk);
        bus.irq_src_i = 4'h1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rel_flag", {24'h0, bus.int_flag_o}, 32'h0);
        rd("rel_enable", 8'h04, 32'h0);
        wr(8'h14, 1);
        wait_rd("rel_edge", 8'h00, 32'h1);
        wr(8'h08, 1);
        wr(8'h04, 1);
        wait_flag("rel_irq", 8'h01);
        bus.irq_src_i = 4'h0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
